sdram_arbiter: RTL

Shares the single-port SDRAM controller request interface (req/ack/we/addr/data, valid/q) among N requesters, e.g. CPU, video fetch and a test engine, all in the clk_cpu domain. Requesters are granted round-robin, and the winner's command is registered and presented to the controller. Read data returning on valid is routed back to the requester that issued the read, using an in-order tag FIFO.

---
 rtl/sdram_arbiter_pkg.sv | 14 +
 rtl/sdram_arb_tag_fifo.sv | 60 ++++++
 rtl/sdram_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/sdram_arbiter_pkg.sv
// Shared types and width helpers for the SDRAM request arbiter.
// IDLE/ISSUE state encoding and clog2 width helper used by the arbiter and its tag FIFO.
package sdram_arbiter_pkg;

    typedef enum logic {
        IDLE,
        ISSUE
    } state_t;

    function automatic int unsigned clog2w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sdram_arb_tag_fifo.sv
// In-order FIFO of requester indices for outstanding reads.
// Pop on empty is ignored; the parent keeps pushes away from a full FIFO.
module sdram_arb_tag_fifo
    import sdram_arbiter_pkg::*;
#(
    parameter int unsigned W     = 2,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int unsigned TW = clog2w(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [TW-1:0] wr_ptr;
    logic [TW-1:0] rd_ptr;
    logic [TW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (TW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + TW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + TW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + (TW+1)'(1);
            end else if (do_pop && !do_push) begin
                count <= count - (TW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller request port among N requesters,
// with in-order routing of read data back to the issuing requester.
module sdram_arbiter
    import sdram_arbiter_pkg::*;
#(
    parameter int unsigned N         = 4,
    parameter int unsigned AW        = 24,
    parameter int unsigned DW        = 32,
    parameter int unsigned TAG_DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [N-1:0]    r_req,
    input  logic [N-1:0]    r_we,
    input  logic [N*AW-1:0] r_addr,
    input  logic [N*DW-1:0] r_data,
    output logic [N-1:0]    r_ack,
    output logic [N-1:0]    r_valid,
    output logic [DW-1:0]   r_q,
    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_data,
    input  logic            mem_ack,
    input  logic            mem_valid,
    input  logic [DW-1:0]   mem_q,
    output logic            busy,
    output logic            err
);

    localparam int unsigned GW = clog2w(N);

    state_t        state;
    logic [GW-1:0] grant;
    logic [GW-1:0] rr;
    logic [N-1:0]  eligible;
    logic          pick_valid;
    logic [GW-1:0] pick_idx;
    logic [AW-1:0] addr_arr [N];
    logic [DW-1:0] data_arr [N];
    logic          tag_push;
    logic [GW-1:0] tag_out;
    logic          tag_full;
    logic          tag_empty;
    logic [N-1:0]  tag_onehot;

    // First eligible index strictly after ptr, wrapping modulo N.
    function automatic logic [GW:0] rr_pick(input logic [N-1:0] elig, input logic [GW-1:0] ptr);
        logic [GW:0] res;
        int unsigned idx;
        res = '0;
        for (int unsigned k = N; k >= 1; k--) begin
            idx = (32'(ptr) + k) % N;
            if (elig[GW'(idx)]) begin
                res = {1'b1, GW'(idx)};
            end
        end
        return res;
    endfunction

    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            addr_arr[i] = r_addr[i*AW +: AW];
            data_arr[i] = r_data[i*DW +: DW];
        end
    end

    assign eligible               = r_req & (r_we | {N{~tag_full}});
    assign {pick_valid, pick_idx} = rr_pick(eligible, rr);
    assign tag_push               = (state == ISSUE) & mem_ack & ~mem_we;
    assign busy                   = (state == ISSUE) | ~tag_empty;

    always_comb begin
        r_ack = '0;
        if (state == ISSUE && mem_ack) begin
            r_ack[grant] = 1'b1;
        end
    end

    always_comb begin
        tag_onehot = '0;
        tag_onehot[tag_out] = 1'b1;
    end

    sdram_arb_tag_fifo #(
        .W     (GW),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (tag_push),
        .pop     (mem_valid),
        .din     (grant),
        .dout    (tag_out),
        .full    (tag_full),
        .empty   (tag_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            grant    <= '0;
            rr       <= GW'(N - 1);
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
            r_valid  <= '0;
            r_q      <= '0;
            err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant    <= pick_idx;
                        mem_we   <= r_we[pick_idx];
                        mem_addr <= addr_arr[pick_idx];
                        mem_data <= data_arr[pick_idx];
                        mem_req  <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        rr      <= grant;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Read return runs independently of the command FSM.
            r_valid <= '0;
            if (mem_valid) begin
                if (!tag_empty) begin
                    r_valid <= tag_onehot;
                    r_q     <= mem_q;
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule
